mem_dbus_ctrl: RTL and testbench

- MEM-stage data-bus initiator: takes the load/store carried by the EX/MEM pipeline register, issues it to the data cache over the dreq/dresp handshake, and returns aligned, extended load data.
- It is the producer of Dwait, the stall signal that the EX/MEM register consumes: Dwait stays high until the access completes, and drops for exactly one cycle so the pipeline advances.

---
 rtl/mem_dbus_ctrl.sv | 141 ++++++++++++++
 tb/tb_mem_dbus_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_dbus_ctrl.sv
// rtl/mem_dbus_ctrl.sv - MEM-stage data-bus initiator: issues EX/MEM loads/stores
// over dreq/dresp, produces the dwait stall and returns aligned, extended load data.
module mem_dbus_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic            req_is_store,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            dreq_valid,
  output logic [XLEN-1:0] dreq_addr,
  output logic [2:0]      dreq_size,
  output logic [7:0]      dreq_strobe,
  output logic [XLEN-1:0] dreq_data,
  input  logic            dresp_addr_ok,
  input  logic            dresp_data_ok,
  input  logic [XLEN-1:0] dresp_data,
  output logic            dwait,
  output logic            done,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]      state;
  logic [XLEN-1:0] lat_addr;
  logic [1:0]      lat_size;
  logic            lat_unsigned;
  logic            lat_store;
  logic [7:0]      lat_strobe;
  logic [XLEN-1:0] lat_wdata;

  logic            accept;
  logic [7:0]      strobe_next;
  logic [XLEN-1:0] wdata_next;
  logic [XLEN-1:0] rd_shifted;
  logic [XLEN-1:0] rd_extended;
  logic [XLEN-1:0] capture;

  assign misaligned = req_valid &
                      (((req_size == 2'd1) & req_addr[0]) |
                       ((req_size == 2'd2) & (|req_addr[1:0])) |
                       ((req_size == 2'd3) & (|req_addr[2:0])));

  assign accept = req_valid & ~misaligned;

  always_comb begin
    strobe_next = 8'h00;
    case (req_size)
      2'd0: strobe_next = 8'h01 << req_addr[2:0];
      2'd1: strobe_next = 8'h03 << {req_addr[2:1], 1'b0};
      2'd2: strobe_next = 8'h0F << {req_addr[2], 2'b00};
      2'd3: strobe_next = 8'hFF;
      default: strobe_next = 8'h00;
    endcase
  end

  assign wdata_next = req_wdata << {req_addr[2:0], 3'b000};

  // Load lane select and extension work off the latched request, not the live inputs.
  assign rd_shifted = dresp_data >> {lat_addr[2:0], 3'b000};

  always_comb begin
    rd_extended = '0;
    case (lat_size)
      2'd0: rd_extended = lat_unsigned ? {56'd0, rd_shifted[7:0]}
                                       : {{56{rd_shifted[7]}}, rd_shifted[7:0]};
      2'd1: rd_extended = lat_unsigned ? {48'd0, rd_shifted[15:0]}
                                       : {{48{rd_shifted[15]}}, rd_shifted[15:0]};
      2'd2: rd_extended = lat_unsigned ? {32'd0, rd_shifted[31:0]}
                                       : {{32{rd_shifted[31]}}, rd_shifted[31:0]};
      2'd3: rd_extended = rd_shifted;
      default: rd_extended = '0;
    endcase
  end

  assign capture = lat_store ? '0 : rd_extended;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      lat_addr     <= '0;
      lat_size     <= '0;
      lat_unsigned <= 1'b0;
      lat_store    <= 1'b0;
      lat_strobe   <= '0;
      lat_wdata    <= '0;
      load_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_addr     <= req_addr;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_store    <= req_is_store;
            lat_strobe   <= req_is_store ? strobe_next : 8'h00;
            lat_wdata    <= wdata_next;
            state        <= REQ;
          end
        end
        REQ: begin
          if (dresp_addr_ok) begin
            if (dresp_data_ok) begin
              load_data <= capture;
              state     <= DONE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dresp_data_ok) begin
            load_data <= capture;
            state     <= DONE;
          end
        end
        // req_valid still shows the completing instruction here, so never re-issue from DONE.
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign dreq_valid  = (state == REQ);
  assign dreq_addr   = lat_addr;
  assign dreq_size   = {1'b0, lat_size};
  assign dreq_strobe = lat_strobe;
  assign dreq_data   = lat_wdata;
  assign done        = (state == DONE);
  assign dwait       = ((state == IDLE) & accept) | (state == REQ) | (state == WAIT);

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// tb/tb_mem_dbus_ctrl.sv - bench for mem_dbus_ctrl: directed and randomized ops
// against a byte-lane arithmetic reference model.
module tb_mem_dbus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_is_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        dwait;
  logic        done;
  logic [63:0] load_data;
  logic        misaligned;

  int n_cmp = 0;
  int n_err = 0;
  int n_req = 0;

  always #5 clk = ~clk;

  mem_dbus_ctrl #(.XLEN(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_is_store(req_is_store), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .dwait(dwait), .done(done), .load_data(load_data), .misaligned(misaligned)
  );

  always @(posedge clk)
    if (!reset && dreq_valid && dresp_addr_ok) n_req <= n_req + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_load(input logic [63:0] rd, input logic [1:0] sz,
                                             input bit uns, input logic [2:0] off);
    int nb = 1 << sz;
    int bits = 8 * nb;
    logic [63:0] sh = rd >> (8 * off);
    logic [63:0] fm = (nb == 8) ? '1 : ((64'h1 << bits) - 64'h1);
    logic [63:0] v = sh & fm;
    if (!uns && nb < 8 && sh[bits-1]) v = v | ~fm;
    return v;
  endfunction

  // One complete access: IDLE-detect cycle, ad+1 REQ cycles, dd WAIT cycles, DONE cycle.
  task automatic run_op(input bit st, input logic [1:0] sz, input bit uns,
                        input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd,
                        input int ad, input int dd);
    logic [2:0]  off = a[2:0];
    int          m = (1 << (1 << sz)) - 1;
    logic [7:0]  exp_strobe = st ? 8'(m << off) : 8'h00;
    logic [63:0] exp_data = wd << (8 * off);
    logic [63:0] exp_ld = st ? 64'd0 : model_load(rd, sz, uns, off);
    int          nwait = 0;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = st; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = $urandom;
    #1;
    chk("idle_dreq_valid", 64'(dreq_valid), 64'd0);
    chk("idle_misaligned", 64'(misaligned), 64'd0);
    nwait += int'(dwait);
    for (int k = 0; k <= ad; k++) begin
      @(negedge clk);
      dresp_addr_ok = (k == ad);
      dresp_data_ok = (k == ad) && (dd == 0);
      dresp_data = (k == ad && dd == 0) ? rd : {$urandom, $urandom};
      #1;
      chk("req_valid", 64'(dreq_valid), 64'd1);
      chk("req_addr", dreq_addr, a);
      chk("req_size", 64'(dreq_size), 64'(sz));
      chk("req_strobe", 64'(dreq_strobe), 64'(exp_strobe));
      if (st) chk("req_data", dreq_data, exp_data);
      nwait += int'(dwait);
    end
    for (int j = 1; j <= dd; j++) begin
      @(negedge clk);
      dresp_addr_ok = 1'b0;
      dresp_data_ok = (j == dd);
      dresp_data = (j == dd) ? rd : {$urandom, $urandom};
      #1;
      chk("wait_dreq_valid", 64'(dreq_valid), 64'd0);
      nwait += int'(dwait);
    end
    @(negedge clk);
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = {$urandom, $urandom};
    #1;
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_dwait", 64'(dwait), 64'd0);
    chk("done_dreq_valid", 64'(dreq_valid), 64'd0);
    chk("load_data", load_data, exp_ld);
    chk("dwait_cycles", 64'(nwait), 64'(2 + ad + dd));
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    req_valid = 1'b0; dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    #1;
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_dwait", 64'(dwait), 64'd0);
  endtask

  initial begin
    int snap;
    reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_dreq_valid", 64'(dreq_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_load_data", load_data, 64'd0);
    chk("rst_dwait", 64'(dwait), 64'd0);

    // Signed byte load, immediate response.
    run_op(1'b0, 2'd0, 1'b0, 64'h8000_1003, 64'd0, 64'h0000_0000_8000_0000, 0, 0);
    idle_cycle();
    // Half store with slow accept and slow data phase.
    run_op(1'b1, 2'd1, 1'b0, 64'h8000_2006, 64'h1234, 64'd0, 2, 2);
    idle_cycle();
    run_op(1'b0, 2'd2, 1'b1, 64'h8000_0004, 64'd0, 64'hDEAD_BEEF_0000_0000, 0, 1);
    idle_cycle();
    run_op(1'b0, 2'd2, 1'b0, 64'h8000_0004, 64'd0, 64'hDEAD_BEEF_0000_0000, 1, 0);
    idle_cycle();

    // Misaligned requests never issue, even with stray responses present.
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b0; req_size = 2'd3; req_addr = 64'h8000_0004;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
    snap = n_req;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mis_flag", 64'(misaligned), 64'd1);
      chk("mis_dwait", 64'(dwait), 64'd0);
      chk("mis_dreq_valid", 64'(dreq_valid), 64'd0);
      chk("mis_done", 64'(done), 64'd0);
      @(negedge clk);
    end
    req_size = 2'd1; req_addr = 64'h8000_0001;
    #1 chk("mis_half", 64'(misaligned), 64'd1);
    req_size = 2'd2; req_addr = 64'h8000_0002;
    #1 chk("mis_word", 64'(misaligned), 64'd1);
    req_valid = 1'b0;
    #1 chk("mis_gated", 64'(misaligned), 64'd0);
    chk("mis_no_req", 64'(n_req), 64'(snap));
    idle_cycle();

    // Back-to-back ld then sd, req_valid held through DONE.
    snap = n_req;
    run_op(1'b0, 2'd3, 1'b0, 64'h8000_0010, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 0);
    run_op(1'b1, 2'd3, 1'b0, 64'h8000_0018, 64'hCAFE_F00D_1122_3344, 64'd0, 1, 0);
    idle_cycle();
    chk("b2b_req_count", 64'(n_req - snap), 64'd2);

    // Randomized traffic.
    for (int t = 0; t < 24; t++) begin
      logic [1:0]  sz = 2'($urandom_range(0, 3));
      logic [63:0] a = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFF8)};
      a[2:0] = 3'($urandom_range(0, 7) & ~((1 << sz) - 1));
      run_op(1'($urandom), sz, 1'($urandom), a, {$urandom, $urandom}, {$urandom, $urandom},
             $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    // Reset while in WAIT abandons the access; a late data_ok is ignored.
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b0; req_size = 2'd3; req_addr = 64'h8000_0020;
    @(negedge clk);
    dresp_addr_ok = 1'b1;
    @(negedge clk);
    dresp_addr_ok = 1'b0;
    #1;
    chk("wait_dwait", 64'(dwait), 64'd1);
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rstw_dreq_valid", 64'(dreq_valid), 64'd0);
    chk("rstw_dwait", 64'(dwait), 64'd0);
    chk("rstw_done", 64'(done), 64'd0);
    chk("rstw_load_data", load_data, 64'd0);
    @(negedge clk);
    dresp_data_ok = 1'b1; dresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    #1;
    chk("late_done", 64'(done), 64'd0);
    chk("late_load_data", load_data, 64'd0);
    chk("late_dwait", 64'(dwait), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
